// File: rtl/req_fifo_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : req_fifo_mc_pkg
//  Description : Shared types for the multi-channel request input buffer.
//                Contains the request packet and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package req_fifo_mc_pkg;

  // Request packet carried from the requester ports to the dispatcher
  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  src;
    logic [19:0] addr;
  } req_pkt_type;

  // Output arbiter: ARB searches round-robin, HOLD freezes an unaccepted grant
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage : req_fifo_mc_pkg
`default_nettype wire

// File: rtl/req_chan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : req_chan_fifo
//  Description : One channel of the request buffer. Circular storage with
//                read/write pointers, occupancy level, full / almost-full
//                flags and a sticky overflow bit. A push into a full channel
//                is accepted only when the same cycle also pops it.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_chan_fifo
  import req_fifo_mc_pkg::*;
#(
  parameter  int DEPTH     = 4,
  parameter  int AF_MARGIN = 1,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_push,
  input  req_pkt_type       i_pkt,
  input  logic              i_pop,
  input  logic              i_err_clr,
  output req_pkt_type       o_head,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_afull,
  output logic [PTR_W:0]    o_level,
  output logic              o_overflow
);

  localparam logic [PTR_W:0] c_FULL_LVL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] c_AF_LVL   = (PTR_W+1)'(DEPTH - AF_MARGIN);

  req_pkt_type        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_level;
  logic               r_overflow;

  logic               w_wr_accept;
  logic               w_drop;

  // A full channel still takes a push when the same cycle frees a slot
  assign w_wr_accept = i_push & (~o_full | i_pop);
  assign w_drop      = i_push & o_full & ~i_pop;

  assign o_level    = r_level;
  assign o_full     = (r_level == c_FULL_LVL);
  assign o_afull    = (r_level >= c_AF_LVL);
  assign o_empty    = (r_level == '0);
  assign o_overflow = r_overflow;
  // No bypass: the head is always read from storage
  assign o_head     = r_mem[r_rd_ptr];

  // Storage write; contents are cleared on reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= i_pkt;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_accept, i_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow; a clear in the same cycle as a drop discards the drop
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_overflow <= 1'b0;
    end else if (i_err_clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule : req_chan_fifo
`default_nettype wire

// File: rtl/req_fifo_mc.sv
`default_nettype none
// ============================================================================
//  Module      : req_fifo_mc
//  Description : Multi-channel request input buffer. NCH independent FIFOs,
//                one per requester, drained through a single valid/ready
//                output by a round-robin arbiter. An offered but unaccepted
//                grant is frozen until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_fifo_mc
  import req_fifo_mc_pkg::*;
#(
  parameter  int NCH       = 4,
  parameter  int DEPTH     = 4,
  parameter  int AF_MARGIN = 1,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CH_W      = $clog2(NCH)
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic [NCH-1:0]              wr_en,
  input  req_pkt_type [NCH-1:0]       wr_req,
  output logic [NCH-1:0]              full,
  output logic [NCH-1:0]              almost_full,
  output logic [NCH-1:0][PTR_W:0]     level,
  output logic [NCH-1:0]              overflow,
  input  logic                        err_clr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output req_pkt_type                 out_req,
  output logic [CH_W-1:0]             out_chan
);

  arb_state_e        r_state;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_grant;

  logic [NCH-1:0]    w_empty;
  logic [NCH-1:0]    w_pop;
  req_pkt_type       w_head [NCH];
  logic [CH_W-1:0]   w_arb_grant;
  logic              w_arb_found;
  logic [CH_W-1:0]   w_grant;
  logic              w_handshake;

  // Channel index modulo NCH (NCH need not be a power of two)
  function automatic logic [CH_W-1:0] f_wrap(input int v);
    return CH_W'(v % NCH);
  endfunction

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chan
      assign w_pop[g] = w_handshake & (w_grant == CH_W'(g));

      req_chan_fifo #(
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
      ) u_fifo (
        .clk        (clk),
        .rst_b      (rst_b),
        .i_push     (wr_en[g]),
        .i_pkt      (wr_req[g]),
        .i_pop      (w_pop[g]),
        .i_err_clr  (err_clr),
        .o_head     (w_head[g]),
        .o_empty    (w_empty[g]),
        .o_full     (full[g]),
        .o_afull    (almost_full[g]),
        .o_level    (level[g]),
        .o_overflow (overflow[g])
      );
    end
  endgenerate

  // Round-robin search: first non-empty channel starting at r_rr_ptr
  always_comb begin
    w_arb_grant = r_rr_ptr;
    w_arb_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_arb_found && !w_empty[f_wrap(int'(r_rr_ptr) + i)]) begin
        w_arb_found = 1'b1;
        w_arb_grant = f_wrap(int'(r_rr_ptr) + i);
      end
    end
  end

  // In HOLD the latched grant owns the output; its channel cannot drain
  // without a pop, so out_valid stays high there as well
  assign w_grant     = (r_state == HOLD) ? r_grant : w_arb_grant;
  assign out_valid   = ~&w_empty;
  assign w_handshake = out_valid & out_ready;
  assign out_chan    = w_grant;
  assign out_req     = out_valid ? w_head[w_grant] : '0;

  // Arbiter FSM: advance the round-robin pointer past each accepted channel
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= ARB;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_handshake) begin
            r_rr_ptr <= f_wrap(int'(w_arb_grant) + 1);
            r_grant  <= w_arb_grant;
          end else if (out_valid) begin
            r_grant <= w_arb_grant;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_handshake) begin
            r_rr_ptr <= f_wrap(int'(r_grant) + 1);
            r_state  <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule : req_fifo_mc
`default_nettype wire

// File: tb/tb_req_fifo_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_fifo_mc
//  Description : Directed and randomized self-checking bench for req_fifo_mc
//                (NCH=4, DEPTH=4, AF_MARGIN=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_fifo_mc;
  import req_fifo_mc_pkg::*;

  localparam int NCH       = 4;
  localparam int DEPTH     = 4;
  localparam int AF_MARGIN = 1;
  localparam int PTR_W     = 2;
  localparam int CH_W      = 2;

  logic                     clk = 1'b0;
  logic                     rst_b;
  logic [NCH-1:0]           wr_en;
  req_pkt_type [NCH-1:0]    wr_req;
  logic [NCH-1:0]           full;
  logic [NCH-1:0]           almost_full;
  logic [NCH-1:0][PTR_W:0]  level;
  logic [NCH-1:0]           overflow;
  logic                     err_clr;
  logic                     out_valid;
  logic                     out_ready;
  req_pkt_type              out_req;
  logic [CH_W-1:0]          out_chan;

  int n_cmp = 0;
  int n_mis = 0;

  req_pkt_type q [NCH][$];
  logic [NCH-1:0] ovm;

  always #5 clk = ~clk;

  req_fifo_mc #(
    .NCH       (NCH),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .wr_en       (wr_en),
    .wr_req      (wr_req),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .err_clr     (err_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_req     (out_req),
    .out_chan    (out_chan)
  );

  function automatic req_pkt_type mk(input int ch, input int id);
    req_pkt_type p;
    p.id   = 8'(id);
    p.src  = 4'(ch);
    p.addr = 20'(id * 37 + ch * 1000 + 5);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; all outputs are registered-derived, so checks just
  // after the edge see the settled post-edge state
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic any;
    int   id_ctr;
    int   popc;

    wr_en = '0; wr_req = '0; out_ready = 1'b0; err_clr = 1'b0; rst_b = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_req",   out_req, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_full",  full, 0);
    chk("rst_af",    almost_full, 0);
    chk("rst_chan",  out_chan, 0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    // ---- reset in the middle of traffic
    cyc();
    wr_en = 4'b0011; wr_req[0] = mk(0, 1); wr_req[1] = mk(1, 1);
    cyc();
    wr_req[0] = mk(0, 2); wr_req[1] = mk(1, 2);
    cyc();
    chk("t1_lvl0", level[0], 2);
    chk("t1_lvl1", level[1], 2);
    wr_en = 4'b1111; out_ready = 1'b1;
    cyc();
    rst_b = 1'b0;
    #1;
    chk("t1_rst_valid", out_valid, 0);
    chk("t1_rst_req",   out_req, 0);
    chk("t1_rst_level", level, 0);
    chk("t1_rst_ovf",   overflow, 0);
    wr_en = '0; out_ready = 1'b0;
    cyc();
    rst_b = 1'b1;
    cyc();
    chk("t1_post_level", level, 0);
    chk("t1_post_valid", out_valid, 0);

    // ---- fill ch2, almost-full, full, overflow, clear
    for (int k = 1; k <= 4; k++) begin
      wr_en = 4'b0100; wr_req[2] = mk(2, k);
      cyc();
      chk("t2_lvl2", level[2], k);
      chk("t2_full2", full[2], (k == 4) ? 1 : 0);
      chk("t2_af2", almost_full[2], (k >= 3) ? 1 : 0);
    end
    chk("t2_valid", out_valid, 1);
    chk("t2_chan",  out_chan, 2);
    chk("t2_req",   out_req, mk(2, 1));
    wr_req[2] = mk(2, 99);
    cyc();
    chk("t2_ovf_set", overflow, 4'b0100);
    chk("t2_lvl_keep", level[2], 4);
    wr_en = '0; err_clr = 1'b1;
    cyc();
    chk("t2_ovf_clr", overflow, 0);
    wr_en = 4'b0100;
    cyc();
    chk("t2_clr_wins", overflow, 0);
    wr_en = '0; err_clr = 1'b0;
    cyc();
    chk("t2_ovf_stay0", overflow, 0);
    chk("t2_lvl_after", level[2], 4);

    // ---- full channel: pop and push in the same cycle
    out_ready = 1'b1; wr_en = 4'b0100; wr_req[2] = mk(2, 5);
    cyc();
    wr_en = '0;
    chk("t3_lvl2", level[2], 4);
    chk("t3_req2", out_req, mk(2, 2));
    for (int k = 3; k <= 5; k++) begin
      cyc();
      chk("t3_req_seq", out_req, mk(2, k));
    end
    cyc();
    chk("t3_empty_valid", out_valid, 0);
    chk("t3_empty_lvl", level[2], 0);
    out_ready = 1'b0;

    // ---- round robin across all channels (fresh rr pointer)
    rst_b = 1'b0;
    cyc();
    rst_b = 1'b1;
    cyc();
    wr_en = 4'b1111;
    for (int c = 0; c < NCH; c++) wr_req[c] = mk(c, 16 * c);
    cyc();
    for (int c = 0; c < NCH; c++) wr_req[c] = mk(c, 16 * c + 1);
    cyc();
    wr_en = '0;
    chk("t4_levels", level, 12'b010_010_010_010);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t4_chan", out_chan, k % 4);
      chk("t4_req", out_req, mk(k % 4, 16 * (k % 4) + k / 4));
      cyc();
    end
    chk("t4_drained", out_valid, 0);
    out_ready = 1'b0;

    // ---- held grant on ch3 survives a push on ch0
    wr_en = 4'b1000; wr_req[3] = mk(3, 8'h31);
    cyc();
    wr_en = 4'b0001; wr_req[0] = mk(0, 8'h01);
    cyc();
    wr_en = '0;
    chk("t5_hold_chan", out_chan, 3);
    chk("t5_hold_req", out_req, mk(3, 8'h31));
    cyc();
    chk("t5_hold_chan2", out_chan, 3);
    chk("t5_hold_req2", out_req, mk(3, 8'h31));
    out_ready = 1'b1;
    cyc();
    chk("t5_next_chan", out_chan, 0);
    chk("t5_next_req", out_req, mk(0, 8'h01));
    cyc();
    out_ready = 1'b0;
    chk("t5_empty", out_valid, 0);

    // ---- random traffic against a queue model
    ovm = '0;
    id_ctr = 0;
    for (int n = 0; n < 3000; n++) begin
      any = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        chk("rnd_level", level[c], q[c].size());
        if (q[c].size() != 0) any = 1'b1;
      end
      chk("rnd_ovf", overflow, ovm);
      chk("rnd_valid", out_valid, any);
      if (out_valid) chk("rnd_req", out_req, q[out_chan][0]);

      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NCH; c++) begin
        wr_en[c]       = ($urandom_range(0, 9) < 4);
        wr_req[c]      = mk(c, id_ctr);
        wr_req[c].addr = 20'($urandom);
        id_ctr++;
      end

      popc = -1;
      if (out_valid && out_ready) begin
        popc = int'(out_chan);
        void'(q[popc].pop_front());
      end
      for (int c = 0; c < NCH; c++) begin
        if (wr_en[c]) begin
          if (q[c].size() < DEPTH) q[c].push_back(wr_req[c]);
          else ovm[c] = 1'b1;
        end
      end
      if (err_clr) ovm = '0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_req_fifo_mc
`default_nettype wire
